// File: rtl/fire_expand_pw_engine.sv
// Pointwise (1x1) expand-convolution engine: DSP_NO parallel MAC lanes accumulate CHIN
// channels per pixel, then bias, shift, optional ReLU and saturation produce one ofm vector.
module fire_expand_pw_engine #(
    parameter int WOUT   = 16,
    parameter int DSP_NO = 64,
    parameter int CHIN   = 64,
    parameter int WIDTH  = 16,
    parameter int FRAC   = 14,
    parameter int RELU   = 1,
    parameter int SAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          layer_en,
    input  logic [WIDTH-1:0]              ifm,
    input  logic                          ifm_valid,
    input  logic [DSP_NO*WIDTH-1:0]       weights,
    input  logic [DSP_NO*2*WIDTH-1:0]     bias,
    output logic [$clog2(CHIN)-1:0]       weight_addr,
    input  logic                          ram_feedback,
    output logic [DSP_NO*WIDTH-1:0]       ofm,
    output logic                          sample,
    output logic                          busy,
    output logic                          finish
);
    localparam int CW   = $clog2(CHIN);
    localparam int AW   = 2*WIDTH + CW;
    localparam int SW   = AW + 1;
    localparam int NPIX = WOUT*WOUT;
    localparam int PW   = $clog2(NPIX+1);

    localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, EMIT, DONE} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           ch;
    logic [PW-1:0]           pix;
    logic                    fb_latched;
    logic                    accept;
    logic                    last_ch;
    logic                    last_pix;
    logic signed [AW-1:0]    acc  [DSP_NO];
    logic signed [2*WIDTH-1:0] prod [DSP_NO];
    logic signed [SW-1:0]    s;
    logic [DSP_NO*WIDTH-1:0] ofm_nx;

    assign accept      = layer_en & ifm_valid & (state == ACC);
    assign last_ch     = (ch == CW'(CHIN-1));
    assign last_pix    = (pix == PW'(NPIX-1));
    assign weight_addr = ch;
    assign busy        = (state == ACC) || (state == EMIT);
    assign finish      = (state == DONE) && !fb_latched;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (layer_en) state_nx = ACC;
            ACC:  if (accept && last_ch) state_nx = EMIT;
            EMIT: state_nx = last_pix ? DONE : ACC;
            DONE: if (!layer_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < DSP_NO; i++) begin
            prod[i] = (2*WIDTH)'($signed(ifm)) * (2*WIDTH)'($signed(weights[i*WIDTH +: WIDTH]));
        end
    end

    // Post-processing order matters: bias at accumulator scale, then shift, ReLU, clamp/wrap.
    always_comb begin
        s      = '0;
        ofm_nx = '0;
        for (int unsigned i = 0; i < DSP_NO; i++) begin
            s = SW'(acc[i]) + SW'($signed(bias[i*2*WIDTH +: 2*WIDTH]));
            s = s >>> FRAC;
            if (RELU != 0 && s < 0) s = '0;
            if (SAT != 0) begin
                if (s > SMAX)      s = SMAX;
                else if (s < SMIN) s = SMIN;
            end
            ofm_nx[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch         <= '0;
            pix        <= '0;
            fb_latched <= 1'b0;
            sample     <= 1'b0;
            ofm        <= '0;
            for (int unsigned i = 0; i < DSP_NO; i++) acc[i] <= '0;
        end else begin
            sample <= (state == EMIT);
            case (state)
                IDLE: if (layer_en) begin
                    ch         <= '0;
                    pix        <= '0;
                    fb_latched <= 1'b0;
                    for (int unsigned i = 0; i < DSP_NO; i++) acc[i] <= '0;
                end
                ACC: if (accept) begin
                    ch <= last_ch ? '0 : ch + 1'b1;
                    for (int unsigned i = 0; i < DSP_NO; i++) acc[i] <= acc[i] + AW'(prod[i]);
                end
                EMIT: begin
                    ofm <= ofm_nx;
                    pix <= pix + 1'b1;
                    for (int unsigned i = 0; i < DSP_NO; i++) acc[i] <= '0;
                    // an acknowledge arriving on the edge that enters DONE is kept
                    if (last_pix && ram_feedback) fb_latched <= 1'b1;
                end
                DONE: if (ram_feedback) fb_latched <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fire_expand_pw_engine.sv
// Bench for fire_expand_pw_engine: three configurations (RELU/SAT variants) share one
// stimulus stream; outputs are compared against a per-pixel arithmetic reference.
module tb_fire_expand_pw_engine;
    localparam int WOUT = 2, DSP_NO = 2, CHIN = 4, WIDTH = 16, FRAC = 2;

    logic        clk = 1'b0;
    logic        rst, layer_en, ifm_valid, ram_feedback;
    logic [15:0] ifm;
    logic [31:0] weights;
    logic [63:0] bias;
    logic [1:0]  waddr    [3];
    logic [31:0] ofm      [3];
    logic        sample_o [3];
    logic        busy_o   [3];
    logic        finish_o [3];

    int n_cmp = 0, n_bad = 0, cyc = 0;

    logic signed [15:0] px_ifm [4];
    logic signed [15:0] px_w   [4][2];
    int                 bias_v [2];
    logic [31:0]        prev   [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fire_expand_pw_engine #(.WOUT(WOUT), .DSP_NO(DSP_NO), .CHIN(CHIN), .WIDTH(WIDTH),
        .FRAC(FRAC), .RELU(1), .SAT(1)) d0 (.clk(clk), .rst(rst), .layer_en(layer_en),
        .ifm(ifm), .ifm_valid(ifm_valid), .weights(weights), .bias(bias),
        .weight_addr(waddr[0]), .ram_feedback(ram_feedback), .ofm(ofm[0]),
        .sample(sample_o[0]), .busy(busy_o[0]), .finish(finish_o[0]));
    fire_expand_pw_engine #(.WOUT(WOUT), .DSP_NO(DSP_NO), .CHIN(CHIN), .WIDTH(WIDTH),
        .FRAC(FRAC), .RELU(0), .SAT(1)) d1 (.clk(clk), .rst(rst), .layer_en(layer_en),
        .ifm(ifm), .ifm_valid(ifm_valid), .weights(weights), .bias(bias),
        .weight_addr(waddr[1]), .ram_feedback(ram_feedback), .ofm(ofm[1]),
        .sample(sample_o[1]), .busy(busy_o[1]), .finish(finish_o[1]));
    fire_expand_pw_engine #(.WOUT(WOUT), .DSP_NO(DSP_NO), .CHIN(CHIN), .WIDTH(WIDTH),
        .FRAC(FRAC), .RELU(1), .SAT(0)) d2 (.clk(clk), .rst(rst), .layer_en(layer_en),
        .ifm(ifm), .ifm_valid(ifm_valid), .weights(weights), .bias(bias),
        .weight_addr(waddr[2]), .ram_feedback(ram_feedback), .ofm(ofm[2]),
        .sample(sample_o[2]), .busy(busy_o[2]), .finish(finish_o[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic b, input logic f, input logic s);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_busy%0d", tag, d),   64'(busy_o[d]),   64'(b));
            chk($sformatf("%s_finish%0d", tag, d), 64'(finish_o[d]), 64'(f));
            chk($sformatf("%s_sample%0d", tag, d), 64'(sample_o[d]), 64'(s));
        end
    endtask

    // Reference: full-precision dot product, then bias, shift, ReLU, clamp or wrap.
    function automatic logic [15:0] ref_lane(input int lane, input bit relu, input bit sat);
        longint sum;
        sum = longint'(bias_v[lane]);
        for (int c = 0; c < CHIN; c++) sum += longint'(px_ifm[c]) * longint'(px_w[c][lane]);
        sum = sum >>> FRAC;
        if (relu && sum < 0) sum = 0;
        if (sat) begin
            if (sum > 32767)       sum = 32767;
            else if (sum < -32768) sum = -32768;
        end
        return sum[15:0];
    endfunction

    function automatic logic [31:0] exp_vec(input int d);
        return {ref_lane(1, d != 1, d != 2), ref_lane(0, d != 1, d != 2)};
    endfunction

    task automatic set_bias(input int b0, input int b1);
        bias_v[0] = b0;
        bias_v[1] = b1;
        bias = {32'(b1), 32'(b0)};
    endtask

    task automatic const_pixel(input logic [15:0] iv, input logic [15:0] w0, input logic [15:0] w1);
        for (int c = 0; c < CHIN; c++) begin
            px_ifm[c] = iv; px_w[c][0] = w0; px_w[c][1] = w1;
        end
    endtask

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 600) - 300);
    endfunction

    task automatic rand_pixel();
        for (int c = 0; c < CHIN; c++) begin
            px_ifm[c] = rnd16(); px_w[c][0] = rnd16(); px_w[c][1] = rnd16();
        end
    endtask

    task automatic start_layer();
        layer_en = 1'b1;
        @(negedge clk);
        chk_ctrl("start", 1'b1, 1'b0, 1'b0);
        chk("start_waddr", 64'(waddr[0]), 64'd0);
    endtask

    // stall_at in 1..3 inserts stall_len idle cycles before that channel (4 = no stall).
    task automatic run_pixel(input int stall_at, input int stall_len, input bit stall_le,
                             input bit emit_le0, input bit last);
        logic [31:0] e [3];
        int t0, n, lat;
        for (int d = 0; d < 3; d++) e[d] = exp_vec(d);
        t0 = 0;
        for (int c = 0; c < CHIN; c++) begin
            if (c == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    layer_en = !stall_le; ifm_valid = stall_le;
                    ifm = 16'($urandom); weights = $urandom;
                    @(negedge clk);
                    for (int d = 0; d < 3; d++) chk("stall_waddr", 64'(waddr[d]), 64'(c));
                    chk("stall_busy", 64'(busy_o[0]), 64'd1);
                end
            end
            layer_en = 1'b1; ifm_valid = 1'b1; ifm = px_ifm[c];
            weights = {px_w[c][1], px_w[c][0]};
            for (int d = 0; d < 3; d++) chk("waddr", 64'(waddr[d]), 64'(c));
            if (c == 0) t0 = cyc;
            @(negedge clk);
            if (c == 0) chk("sample_one_cycle", 64'(sample_o[0]), 64'd0);
        end
        ifm_valid = 1'b0; ifm = 16'($urandom); layer_en = !emit_le0;
        for (int d = 0; d < 3; d++) chk("ofm_hold", 64'(ofm[d]), 64'(prev[d]));
        chk_ctrl("emit", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n = 0;
        while (sample_o[0] !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        layer_en = 1'b1;
        lat = cyc - t0;
        chk("latency", 64'(lat), 64'(CHIN + 1 + ((stall_at >= 1 && stall_at < CHIN) ? stall_len : 0)));
        for (int d = 0; d < 3; d++) chk($sformatf("ofm%0d", d), 64'(ofm[d]), 64'(e[d]));
        chk_ctrl("pix_end", !last, last, 1'b1);
        for (int d = 0; d < 3; d++) prev[d] = e[d];
    endtask

    task automatic finish_layer(input bit early);
        if (!early) begin
            @(negedge clk);
            chk_ctrl("done_hold", 1'b0, 1'b1, 1'b0);
        end
        ram_feedback = 1'b1;
        @(negedge clk);
        ram_feedback = 1'b0;
        chk_ctrl("fb_ack", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctrl("fb_sticky", 1'b0, 1'b0, 1'b0);
        layer_en = 1'b0;
        @(negedge clk);
        chk_ctrl("idle", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_layer(input bit early);
        set_bias(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000);
        start_layer();
        for (int p = 0; p < WOUT*WOUT; p++) begin
            rand_pixel();
            run_pixel(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'($urandom),
                      p == 1, p == WOUT*WOUT-1);
        end
        finish_layer(early);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; layer_en = 1'b0; ifm_valid = 1'b0; ram_feedback = 1'b0;
        ifm = '0; weights = '0; bias = '0; bias_v[0] = 0; bias_v[1] = 0;
        for (int d = 0; d < 3; d++) prev[d] = '0;
        repeat (3) @(negedge clk);
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk("reset_ofm", 64'(ofm[d]), 64'd0);
        chk("reset_waddr", 64'(waddr[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed layer: basic MAC, activation, saturation, stall
        set_bias(0, 0);
        start_layer();
        const_pixel(16'd4, 16'd4, 16'd4);
        run_pixel(4, 0, 1'b0, 1'b0, 1'b0);
        chk("mac_basic", 64'(ofm[0]), 64'h0010_0010);
        const_pixel(16'd4, 16'd4, 16'hFFFC);
        run_pixel(4, 0, 1'b0, 1'b0, 1'b0);
        chk("relu_on", 64'(ofm[0]), 64'h0000_0010);
        chk("relu_off", 64'(ofm[1]), 64'hFFF0_0010);
        const_pixel(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_pixel(4, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_on", 64'(ofm[0]), 64'h7FFF_7FFF);
        chk("sat_off", 64'(ofm[2]), 64'h0001_0001);
        const_pixel(16'd4, 16'd4, 16'd4);
        run_pixel(2, 3, 1'b0, 1'b0, 1'b1);
        chk("stall_ofm", 64'(ofm[0]), 64'h0010_0010);
        finish_layer(1'b0);

        rand_layer(1'b0);
        rand_layer(1'b1);

        // reset in the middle of pixel 2, then a full recomputed layer
        set_bias(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
        start_layer();
        for (int p = 0; p < 2; p++) begin
            rand_pixel();
            run_pixel(4, 0, 1'b0, 1'b0, 1'b0);
        end
        rand_pixel();
        for (int c = 0; c < 2; c++) begin
            ifm_valid = 1'b1; ifm = px_ifm[c]; weights = {px_w[c][1], px_w[c][0]};
            @(negedge clk);
        end
        rst = 1'b1; ram_feedback = 1'b1;
        @(negedge clk);
        chk_ctrl("rst_mid", 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk("rst_ofm", 64'(ofm[d]), 64'd0);
        chk("rst_waddr", 64'(waddr[0]), 64'd0);
        @(negedge clk);
        chk("rst_priority", 64'(busy_o[0]), 64'd0);
        rst = 1'b0; ram_feedback = 1'b0; ifm_valid = 1'b0;
        for (int d = 0; d < 3; d++) prev[d] = '0;
        @(negedge clk);
        chk("rst_restart", 64'(busy_o[0]), 64'd1);
        for (int p = 0; p < WOUT*WOUT; p++) begin
            rand_pixel();
            run_pixel(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'($urandom),
                      1'b0, p == WOUT*WOUT-1);
        end
        finish_layer(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
